smc_stream: RTL and testbench
=============================

Name: smc_stream

Overview:
- Parametrised, sequential successor to the fixed six-channel sorting MOSFET calculator.
- Accepts N_CH MOSFET channels as a stream, one channel per beat, and computes each channel's drain current or transconductance.
- Keeps the values in a running insertion-sorted array and outputs the sum of the K largest or K smallest values.
- Sits between the stimulus driver (mem_intf-style interface) and the scoreboard in the SMC lab environment.

Parameters:
- N_CH, 6: channels per frame (>=2).
- K, 3: number of values summed (1..N_CH).
- W_W, 3: width of W input, unsigned.
- V_W, 3: width of V_GS and V_DS inputs, unsigned.
- VAL_W, W_W+2*V_W+1: width of one computed value and of each sort register.
- OUT_W, VAL_W+$clog2(K+1): width of out_n.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  block can accept a beat.
- mode  in  2  bit0: 1=Id, 0=gm; bit1: 1=largest K, 0=smallest K. Sampled on the first beat of a frame only.
- W  in  W_W  channel width.
- V_GS  in  V_W  gate-source voltage.
- V_DS  in  V_W  drain-source voltage.
- out_n  out  OUT_W  frame result.
- out_valid  out  1  one-cycle result strobe.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port named clk, reset port named reset.
- Reset: state=IDLE; beat count=0; sort array all 0; out_n=0; out_valid=0; mode register=0; in_ready=1 after reset deasserts.
- Reset asserted mid-frame or during SUM/OUT aborts the frame. No out_valid is produced for that frame.
- Handshake: a beat is accepted on an edge where in_valid && in_ready.
  - in_ready = (state==IDLE || state==LOAD).
  - in_valid while in_ready=0 is ignored and does not stall.
- Per-beat computation (combinational, integer math, Vth=1, Vov=V_GS-1):
  - Cutoff, V_GS<=1: value=0.
  - Triode, Vov>V_DS: Id=floor(W*(2*Vov*V_DS - V_DS^2)/3); gm=floor(2*W*V_DS/3).
  - Saturation, Vov<=V_DS: Id=floor(W*Vov^2/3); gm=floor(2*W*Vov/3).
  - Intermediate products sized to VAL_W+2 with no truncation before the divide.
  - Id or gm is selected by the latched mode bit0; on the first beat the incoming mode is used directly.
- Sort array S[0..N_CH-1] is kept in descending order.
  - Each accepted beat inserts its value at the first index i where value > S[i]; entries at index >=i shift down one.
  - Ties: the new value goes after existing equal values (stable).
  - The first beat of a frame overwrites the whole array: S[0]=value, rest=0.
- FSM:
  - IDLE: on an accepted beat, latch mode, count=1 -> LOAD. If N_CH==1 is impossible, so always -> LOAD.
  - LOAD: each accepted beat increments count; the beat that makes count==N_CH -> SUM. Idle cycles (in_valid=0) are allowed between beats with no timeout.
  - SUM: one cycle. Registers out_n = S[0]+..+S[K-1] if mode bit1=1, else S[N_CH-K]+..+S[N_CH-1]; sets out_valid=1 -> OUT.
  - OUT: out_valid=1 for exactly this cycle; at the next edge out_valid=0 -> IDLE.
  - out_n holds its value until the next frame's SUM or until reset.
- Latency: last beat accepted at edge E; out_valid is high between edges E+1 and E+2; in_ready returns high after E+2.
- Frames are back-to-back with a 2-cycle bubble. Beats offered during SUM/OUT are dropped, so the driver must honour in_ready.

Test Plan:
- Id, largest, saturation: V_GS=3, V_DS=4, W=1..6 over 6 beats, mode=2'b11 -> values 1,2,4,5,6,8; out_n=19, one-cycle out_valid at E+1.
- Same beats with mode=2'b01 (Id, smallest) -> out_n=7. Same beats with mode=2'b00 (gm sat = floor(4W/3)) -> out_n=7.
- Triode and cutoff mix, mode=2'b11:
  - W=7, V_GS=5, V_DS=2 -> Id=28.
  - W=7, V_GS=1, V_DS=7 -> 0.
  - Four beats of W=3, V_GS=2, V_DS=1 (sat, Vov=1) -> 1 each.
  - Expected out_n=28+1+1=30. With mode=2'b10 (gm): 9,0,2,2,2,2 -> out_n=13.
- Ties and ordering: six identical beats W=3, V_GS=4, V_DS=3 (Id=9), mode=2'b11 -> out_n=27; reverse-order W=6..1 frame gives the same result as forward order.
- Handshake and gaps: random in_valid gaps inside a frame; assert in_valid during SUM/OUT -> beats ignored, count unaffected; mode changed mid-frame -> ignored.
- Reset: assert reset after 3 beats -> no out_valid, out_n=0; then a full fresh frame -> correct result. Also re-run all of the above with N_CH=8, K=2 and N_CH=4, K=4.

Source files
------------

// File: rtl/smc_stream_if.sv
// Beat-in / result-out bundle between the SMC stimulus driver and smc_stream.
interface smc_stream_if #(
    parameter int unsigned W_W   = 3,
    parameter int unsigned V_W   = 3,
    parameter int unsigned OUT_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [W_W-1:0]   W;
    logic [V_W-1:0]   V_GS;
    logic [V_W-1:0]   V_DS;
    logic [OUT_W-1:0] out_n;
    logic             out_valid;

    modport master (
        output in_valid, mode, W, V_GS, V_DS,
        input  in_ready, out_n, out_valid
    );

    modport slave (
        input  in_valid, mode, W, V_GS, V_DS,
        output in_ready, out_n, out_valid
    );
endinterface

// File: rtl/smc_stream.sv
// Streaming sorting MOSFET calculator: per-beat Id/gm, running insertion sort,
// sum of the K largest or K smallest values of each N_CH-beat frame.
module smc_stream #(
    parameter int unsigned N_CH  = 6,
    parameter int unsigned K     = 3,
    parameter int unsigned W_W   = 3,
    parameter int unsigned V_W   = 3,
    parameter int unsigned VAL_W = W_W + 2*V_W + 1,
    parameter int unsigned OUT_W = VAL_W + $clog2(K+1)
) (
    input  logic         clk,
    input  logic         reset,
    smc_stream_if.slave  bus
);
    localparam int unsigned PW    = VAL_W + 2;
    localparam int unsigned CNT_W = $clog2(N_CH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SUM, OUT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         mode_q;
    logic [VAL_W-1:0]   s_q   [N_CH];
    logic [VAL_W-1:0]   s_ins [N_CH];
    logic [N_CH-1:0]    gt;
    logic               accept;
    logic               ready_d;
    logic               id_sel;
    logic [PW-1:0]      w_x, vgs_x, vds_x, vov, prod_id, prod_gm, val_full;
    logic [VAL_W-1:0]   value;
    logic [OUT_W-1:0]   sum;

    assign accept = bus.in_valid && (state_q == IDLE || state_q == LOAD);
    // First beat of a frame has no latched mode yet, so it uses the live one.
    assign id_sel = (state_q == IDLE) ? bus.mode[0] : mode_q[0];

    // Square-law device model with Vth=1; products are wide enough to divide exactly.
    always_comb begin
        w_x     = PW'(bus.W);
        vgs_x   = PW'(bus.V_GS);
        vds_x   = PW'(bus.V_DS);
        vov     = vgs_x - PW'(1);
        prod_id = '0;
        prod_gm = '0;
        if (bus.V_GS > V_W'(1)) begin
            if (vov > vds_x) begin
                prod_id = w_x * (vds_x * ((vov << 1) - vds_x));
                prod_gm = (w_x * vds_x) << 1;
            end else begin
                prod_id = w_x * vov * vov;
                prod_gm = (w_x * vov) << 1;
            end
        end
        val_full = (id_sel ? prod_id : prod_gm) / PW'(3);
        value    = VAL_W'(val_full);
    end

    // gt is monotonic over a descending array, so its first set bit is the insert point.
    always_comb begin
        for (int unsigned j = 0; j < N_CH; j++) begin
            gt[j] = value > s_q[j];
        end
        s_ins[0] = gt[0] ? value : s_q[0];
        for (int unsigned j = 1; j < N_CH; j++) begin
            if (!gt[j])        s_ins[j] = s_q[j];
            else if (gt[j-1])  s_ins[j] = s_q[j-1];
            else               s_ins[j] = value;
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned j = 0; j < K; j++) begin
            sum = sum + (mode_q[1] ? OUT_W'(s_q[j]) : OUT_W'(s_q[N_CH-K+j]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = LOAD;
            LOAD: if (accept && cnt_q == CNT_W'(N_CH - 1)) state_d = SUM;
            SUM:  state_d = OUT;
            OUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) || (state_d == LOAD);
    end

    // Frame datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            mode_q        <= '0;
            bus.out_n     <= '0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            for (int unsigned j = 0; j < N_CH; j++) s_q[j] <= '0;
        end else begin
            bus.in_ready  <= ready_d;
            bus.out_valid <= (state_q == SUM);
            if (state_q == SUM) bus.out_n <= sum;
            if (accept) begin
                if (state_q == IDLE) begin
                    mode_q <= bus.mode;
                    cnt_q  <= CNT_W'(1);
                    s_q[0] <= value;
                    for (int unsigned j = 1; j < N_CH; j++) s_q[j] <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    s_q   <= s_ins;
                end
            end
        end
    end
endmodule

// File: tb/tb_smc_stream.sv
// Directed bench for smc_stream in three configurations: 6/3, 8/2 and 4/4.
module tb_smc_stream;
    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [1:0] sel;
    logic [1:0] mode;
    logic [2:0] w, vgs, vds;
    logic       cur_ready, cur_valid;
    int         cur_out;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    smc_stream_if #(.W_W(3), .V_W(3), .OUT_W(12)) bus6 ();
    smc_stream_if #(.W_W(3), .V_W(3), .OUT_W(12)) bus8 ();
    smc_stream_if #(.W_W(3), .V_W(3), .OUT_W(13)) bus4 ();

    assign bus6.in_valid = valid && (sel == 2'd0);
    assign bus8.in_valid = valid && (sel == 2'd1);
    assign bus4.in_valid = valid && (sel == 2'd2);
    assign bus6.mode = mode;  assign bus6.W = w;  assign bus6.V_GS = vgs;  assign bus6.V_DS = vds;
    assign bus8.mode = mode;  assign bus8.W = w;  assign bus8.V_GS = vgs;  assign bus8.V_DS = vds;
    assign bus4.mode = mode;  assign bus4.W = w;  assign bus4.V_GS = vgs;  assign bus4.V_DS = vds;

    smc_stream #(.N_CH(6), .K(3)) dut6 (.clk(clk), .reset(reset), .bus(bus6.slave));
    smc_stream #(.N_CH(8), .K(2)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
    smc_stream #(.N_CH(4), .K(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

    always_comb begin
        cur_ready = bus6.in_ready;
        cur_valid = bus6.out_valid;
        cur_out   = int'(bus6.out_n);
        case (sel)
            2'd1: begin cur_ready = bus8.in_ready; cur_valid = bus8.out_valid; cur_out = int'(bus8.out_n); end
            2'd2: begin cur_ready = bus4.in_ready; cur_valid = bus4.out_valid; cur_out = int'(bus4.out_n); end
            default: ;
        endcase
    end

    // Drives one frame to the selected DUT and reports result, strobe shape and ready shape.
    task automatic run_frame(input int n, input int fw[8], input int fg[8], input int fd[8],
                             input logic [1:0] m, input int gap, input bit mode_flip, input bit flood,
                             output int got_n, output bit pulse_ok, output bit ready_ok);
        got_n = -1; pulse_ok = 1'b0; ready_ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (cur_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
            if (t >= 20) begin
                n_checks++; n_fail++;
                $display("FAIL ready_timeout: in_ready stayed %b, required 1", cur_ready);
                return;
            end
            valid = 1'b1;
            mode  = (mode_flip && i > 0) ? ~m : m;
            w = 3'(fw[i]); vgs = 3'(fg[i]); vds = 3'(fd[i]);
            @(negedge clk);
            valid = 1'b0;
            if (gap > 0 && i < n - 1) repeat ($urandom_range(0, gap)) @(negedge clk);
        end
        pulse_ok = (cur_valid === 1'b0);
        ready_ok = (cur_ready === 1'b0);
        if (flood) begin valid = 1'b1; w = 3'd7; vgs = 3'd7; vds = 3'd7; mode = 2'b11; end
        @(negedge clk);
        if (cur_valid !== 1'b1) pulse_ok = 1'b0;
        if (cur_ready !== 1'b0) ready_ok = 1'b0;
        got_n = cur_out;
        @(negedge clk);
        valid = 1'b0;
        if (cur_valid !== 1'b0) pulse_ok = 1'b0;
        if (cur_out != got_n)   pulse_ok = 1'b0;
        if (cur_ready !== 1'b1) ready_ok = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            n_checks++;
            if (cur_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b want 1", s, cur_ready); end
            n_checks++;
            if (cur_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", s, cur_valid); end
            n_checks++;
            if (cur_out !== 0) begin n_fail++; $display("FAIL reset_out[%0d]: got %0d want 0", s, cur_out); end
        end
        sel = 2'd0;
    endtask

    task automatic test_sat_modes();
        int fw[8], fg[8], fd[8], got; bit p_ok, r_ok;
        logic [1:0] modes[4] = '{2'b11, 2'b01, 2'b00, 2'b10};
        int exps[4] = '{19, 7, 7, 19};
        fw = '{1, 2, 3, 4, 5, 6, 0, 0}; fg = '{3, 3, 3, 3, 3, 3, 0, 0}; fd = '{4, 4, 4, 4, 4, 4, 0, 0};
        sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            run_frame(6, fw, fg, fd, modes[i], 0, 1'b0, 1'b0, got, p_ok, r_ok);
            n_checks++;
            if (got !== exps[i]) begin n_fail++; $display("FAIL sat_sum[%0d]: got %0d want %0d", i, got, exps[i]); end
            n_checks++;
            if (p_ok !== 1'b1) begin n_fail++; $display("FAIL sat_strobe[%0d]: got %b want 1", i, p_ok); end
            n_checks++;
            if (r_ok !== 1'b1) begin n_fail++; $display("FAIL sat_ready[%0d]: got %b want 1", i, r_ok); end
        end
    endtask

    task automatic test_triode_cutoff();
        int fw[8], fg[8], fd[8], got; bit p_ok, r_ok;
        logic [1:0] modes[3] = '{2'b11, 2'b10, 2'b01};
        int exps[3] = '{30, 13, 2};
        fw = '{7, 7, 3, 3, 3, 3, 0, 0}; fg = '{5, 1, 2, 2, 2, 2, 0, 0}; fd = '{2, 7, 1, 1, 1, 1, 0, 0};
        sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            run_frame(6, fw, fg, fd, modes[i], 0, 1'b0, 1'b0, got, p_ok, r_ok);
            n_checks++;
            if (got !== exps[i]) begin n_fail++; $display("FAIL triode_sum[%0d]: got %0d want %0d", i, got, exps[i]); end
            n_checks++;
            if (p_ok !== 1'b1) begin n_fail++; $display("FAIL triode_strobe[%0d]: got %b want 1", i, p_ok); end
        end
    endtask

    task automatic test_back_to_back();
        int fw[8], fg[8], fd[8], got; bit p_ok, r_ok;
        sel = 2'd0;
        fw = '{3, 3, 3, 3, 3, 3, 0, 0}; fg = '{4, 4, 4, 4, 4, 4, 0, 0}; fd = '{3, 3, 3, 3, 3, 3, 0, 0};
        run_frame(6, fw, fg, fd, 2'b11, 0, 1'b0, 1'b0, got, p_ok, r_ok);
        n_checks++;
        if (got !== 27) begin n_fail++; $display("FAIL ties_sum: got %0d want 27", got); end
        fw = '{6, 5, 4, 3, 2, 1, 0, 0}; fg = '{3, 3, 3, 3, 3, 3, 0, 0}; fd = '{4, 4, 4, 4, 4, 4, 0, 0};
        run_frame(6, fw, fg, fd, 2'b11, 0, 1'b0, 1'b0, got, p_ok, r_ok);
        n_checks++;
        if (got !== 19) begin n_fail++; $display("FAIL reverse_large: got %0d want 19", got); end
        run_frame(6, fw, fg, fd, 2'b01, 0, 1'b0, 1'b0, got, p_ok, r_ok);
        n_checks++;
        if (got !== 7) begin n_fail++; $display("FAIL reverse_small: got %0d want 7", got); end
        n_checks++;
        if (p_ok !== 1'b1 || r_ok !== 1'b1) begin n_fail++; $display("FAIL reverse_shape: got %b%b want 11", p_ok, r_ok); end
    endtask

    task automatic test_handshake();
        int fw[8], fg[8], fd[8], got; bit p_ok, r_ok;
        int  gaps[4]  = '{3, 0, 0, 2};
        bit  flips[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bit  floods[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0] modes[4] = '{2'b11, 2'b01, 2'b11, 2'b11};
        int exps[4] = '{19, 7, 19, 19};
        fw = '{1, 2, 3, 4, 5, 6, 0, 0}; fg = '{3, 3, 3, 3, 3, 3, 0, 0}; fd = '{4, 4, 4, 4, 4, 4, 0, 0};
        sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            run_frame(6, fw, fg, fd, modes[i], gaps[i], flips[i], floods[i], got, p_ok, r_ok);
            n_checks++;
            if (got !== exps[i]) begin n_fail++; $display("FAIL hs_sum[%0d]: got %0d want %0d", i, got, exps[i]); end
            n_checks++;
            if (p_ok !== 1'b1 || r_ok !== 1'b1) begin n_fail++; $display("FAIL hs_shape[%0d]: got %b%b want 11", i, p_ok, r_ok); end
        end
    endtask

    task automatic test_midframe_reset();
        int fw[8], fg[8], fd[8], got; bit p_ok, r_ok; bit saw_valid;
        fw = '{1, 2, 3, 4, 5, 6, 0, 0}; fg = '{3, 3, 3, 3, 3, 3, 0, 0}; fd = '{4, 4, 4, 4, 4, 4, 0, 0};
        sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; mode = 2'b11; w = 3'(fw[i]); vgs = 3'd3; vds = 3'd4;
            @(negedge clk);
        end
        valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        saw_valid = 1'b0;
        repeat (8) begin @(negedge clk); if (cur_valid !== 1'b0) saw_valid = 1'b1; end
        n_checks++;
        if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", saw_valid); end
        n_checks++;
        if (cur_out !== 0) begin n_fail++; $display("FAIL abort_out: got %0d want 0", cur_out); end
        n_checks++;
        if (cur_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", cur_ready); end
        run_frame(6, fw, fg, fd, 2'b11, 0, 1'b0, 1'b0, got, p_ok, r_ok);
        n_checks++;
        if (got !== 19) begin n_fail++; $display("FAIL after_abort_sum: got %0d want 19", got); end
    endtask

    task automatic test_n8_k2();
        int aw[8], ag[8], ad[8], tw[8], tg[8], td[8], got; bit p_ok, r_ok;
        aw = '{0, 1, 2, 3, 4, 5, 6, 7}; ag = '{3, 3, 3, 3, 3, 3, 3, 3}; ad = '{4, 4, 4, 4, 4, 4, 4, 4};
        tw = '{7, 3, 3, 7, 3, 3, 3, 3}; tg = '{5, 2, 2, 7, 2, 2, 2, 2}; td = '{2, 1, 1, 7, 1, 1, 1, 1};
        sel = 2'd1;
        run_frame(8, aw, ag, ad, 2'b11, 0, 1'b0, 1'b0, got, p_ok, r_ok);
        n_checks++;
        if (got !== 17) begin n_fail++; $display("FAIL n8_sat_large: got %0d want 17", got); end
        n_checks++;
        if (p_ok !== 1'b1 || r_ok !== 1'b1) begin n_fail++; $display("FAIL n8_shape: got %b%b want 11", p_ok, r_ok); end
        run_frame(8, aw, ag, ad, 2'b01, 2, 1'b0, 1'b0, got, p_ok, r_ok);
        n_checks++;
        if (got !== 1) begin n_fail++; $display("FAIL n8_sat_small: got %0d want 1", got); end
        run_frame(8, aw, ag, ad, 2'b10, 0, 1'b0, 1'b0, got, p_ok, r_ok);
        n_checks++;
        if (got !== 17) begin n_fail++; $display("FAIL n8_gm_large: got %0d want 17", got); end
        run_frame(8, tw, tg, td, 2'b11, 0, 1'b0, 1'b1, got, p_ok, r_ok);
        n_checks++;
        if (got !== 112) begin n_fail++; $display("FAIL n8_triode_large: got %0d want 112", got); end
        run_frame(8, tw, tg, td, 2'b01, 0, 1'b1, 1'b0, got, p_ok, r_ok);
        n_checks++;
        if (got !== 2) begin n_fail++; $display("FAIL n8_triode_small: got %0d want 2", got); end
    endtask

    task automatic test_n4_k4();
        int aw[8], ag[8], ad[8], tw[8], tg[8], td[8], got; bit p_ok, r_ok;
        aw = '{1, 2, 3, 4, 0, 0, 0, 0}; ag = '{3, 3, 3, 3, 0, 0, 0, 0}; ad = '{4, 4, 4, 4, 0, 0, 0, 0};
        tw = '{7, 7, 3, 7, 0, 0, 0, 0}; tg = '{5, 1, 4, 7, 0, 0, 0, 0}; td = '{2, 7, 3, 7, 0, 0, 0, 0};
        sel = 2'd2;
        run_frame(4, aw, ag, ad, 2'b11, 0, 1'b0, 1'b0, got, p_ok, r_ok);
        n_checks++;
        if (got !== 12) begin n_fail++; $display("FAIL n4_sat_id: got %0d want 12", got); end
        n_checks++;
        if (p_ok !== 1'b1 || r_ok !== 1'b1) begin n_fail++; $display("FAIL n4_shape: got %b%b want 11", p_ok, r_ok); end
        run_frame(4, aw, ag, ad, 2'b00, 3, 1'b0, 1'b0, got, p_ok, r_ok);
        n_checks++;
        if (got !== 12) begin n_fail++; $display("FAIL n4_sat_gm: got %0d want 12", got); end
        run_frame(4, tw, tg, td, 2'b11, 0, 1'b0, 1'b0, got, p_ok, r_ok);
        n_checks++;
        if (got !== 121) begin n_fail++; $display("FAIL n4_mix_id: got %0d want 121", got); end
        run_frame(4, tw, tg, td, 2'b00, 0, 1'b1, 1'b1, got, p_ok, r_ok);
        n_checks++;
        if (got !== 43) begin n_fail++; $display("FAIL n4_mix_gm: got %0d want 43", got); end
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; sel = 2'd0; mode = 2'b00;
        w = '0; vgs = '0; vds = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_sat_modes();
        test_triode_cutoff();
        test_back_to_back();
        test_handshake();
        test_midframe_reset();
        test_n8_k2();
        test_n4_k4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
